// File: rtl/clint_multi_hart_if.sv
// Native valid/ready peripheral bus between a CPU and the CLINT.
// master drives requests, slave returns registered read data and ready.
interface clint_multi_hart_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic                  valid;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  ready;

   modport master (
      output valid, address, wdata, wstrb,
      input  rdata, ready
   );

   modport slave (
      input  valid, address, wdata, wstrb,
      output rdata, ready
   );
endinterface

// File: rtl/clint_multi_hart.sv
// Multi-hart core-local interruptor: MSIP, MTIMECMP and a shared MTIME.
// Optional CLINT_MTIME_SNAPSHOT_EN: coherent high-word read via shadow.
module clint_multi_hart #(
   parameter int N_HARTS = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int MTIME_W = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rtc_in,
   clint_multi_hart_if.slave   bus,
   output logic [N_HARTS-1:0]  mtip,
   output logic [N_HARTS-1:0]  msip
);

   function automatic logic [31:0] f_merge(
      input logic [31:0] i_old,
      input logic [31:0] i_new,
      input logic [3:0]  i_stb
   );
      f_merge = i_old;
      for (int b = 0; b < 4; b++) begin
         if (i_stb[b]) f_merge[8*b +: 8] = i_new[8*b +: 8];
      end
   endfunction

   logic [MTIME_W-1:0] r_mtime;
   logic [MTIME_W-1:0] r_cmp [N_HARTS];
   logic [N_HARTS-1:0] r_msip;
   logic [N_HARTS-1:0] r_mtip_o;
   logic [N_HARTS-1:0] r_msip_o;
   logic               r_rtc_s1;
   logic               r_rtc_s2;
   logic               r_rtc_s3;
   logic               r_ready;
   logic [DATA_W-1:0]  r_rdata;

   logic [ADDR_W-1:0]  w_addr_raw;
   logic [31:0]        w_addr;
   logic               w_rd;
   logic               w_wr;
   logic               w_msip_hit;
   logic               w_cmp_hit;
   logic               w_cmp_hi;
   logic               w_mt_lo;
   logic               w_mt_hi;
   logic               w_mt_wr;
   logic               w_tick;
   logic [11:0]        w_msip_idx;
   logic [10:0]        w_cmp_idx;
   logic [63:0]        w_mt64;
   logic [63:0]        w_mt_new64;
   logic [63:0]        w_cmp_sel64;
   logic [63:0]        w_cmp_new64;
   logic [DATA_W-1:0]  w_rval;

   assign w_addr_raw = bus.address;
   assign w_addr     = 32'(w_addr_raw);
   assign w_rd       = bus.valid && (bus.wstrb == '0);
   assign w_wr       = bus.valid && (bus.wstrb != '0);
   assign w_msip_hit = (w_addr[31:14] == 18'h0) && (w_addr[1:0] == 2'b0);
   assign w_cmp_hit  = (w_addr[31:14] == 18'h1) && (w_addr[1:0] == 2'b0);
   assign w_msip_idx = w_addr[13:2];
   assign w_cmp_idx  = w_addr[13:3];
   assign w_cmp_hi   = w_addr[2];
   assign w_mt_lo    = (w_addr == 32'hBFF8);
   assign w_mt_hi    = (w_addr == 32'hBFFC);
   assign w_mt_wr    = w_wr && (w_mt_lo || w_mt_hi);
   assign w_tick     = r_rtc_s2 && !r_rtc_s3;
   assign w_mt64     = 64'(r_mtime);

   assign w_mt_new64 = w_mt_lo
      ? {w_mt64[63:32], f_merge(w_mt64[31:0], bus.wdata, bus.wstrb)}
      : {f_merge(w_mt64[63:32], bus.wdata, bus.wstrb), w_mt64[31:0]};

   assign w_cmp_new64 = w_cmp_hi
      ? {f_merge(w_cmp_sel64[63:32], bus.wdata, bus.wstrb), w_cmp_sel64[31:0]}
      : {w_cmp_sel64[63:32], f_merge(w_cmp_sel64[31:0], bus.wdata, bus.wstrb)};

`ifdef CLINT_MTIME_SNAPSHOT_EN
   logic [MTIME_W-33:0] r_shadow;

   // Shadow of the upper MTIME bits, latched on low-word read or MTIME write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow <= '0;
      end else if (w_mt_wr) begin
         r_shadow <= w_mt_new64[MTIME_W-1:32];
      end else if (w_rd && w_mt_lo) begin
         r_shadow <= r_mtime[MTIME_W-1:32];
      end
   end
`endif

   // Read mux and selected-compare lookup for the current bus address
   always_comb begin
      w_rval      = '0;
      w_cmp_sel64 = '0;
      for (int h = 0; h < N_HARTS; h++) begin
         if (w_cmp_idx == 11'(h)) w_cmp_sel64 = 64'(r_cmp[h]);
      end
      unique case (1'b1)
         w_msip_hit: begin
            for (int h = 0; h < N_HARTS; h++) begin
               if (w_msip_idx == 12'(h)) w_rval = DATA_W'(r_msip[h]);
            end
         end
         w_cmp_hit: begin
            if (32'(w_cmp_idx) < N_HARTS)
               w_rval = w_cmp_hi ? w_cmp_sel64[63:32] : w_cmp_sel64[31:0];
         end
         w_mt_lo: w_rval = w_mt64[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
         w_mt_hi: w_rval = 32'(r_shadow);
`else
         w_mt_hi: w_rval = w_mt64[63:32];
`endif
         default: w_rval = '0;
      endcase
   end

   // RTC synchroniser, edge detect and MTIME counter (bus write beats tick)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rtc_s1 <= 1'b0;
         r_rtc_s2 <= 1'b0;
         r_rtc_s3 <= 1'b0;
         r_mtime  <= '0;
      end else begin
         r_rtc_s1 <= rtc_in;
         r_rtc_s2 <= r_rtc_s1;
         r_rtc_s3 <= r_rtc_s2;
         if (w_mt_wr) begin
            r_mtime <= w_mt_new64[MTIME_W-1:0];
         end else if (w_tick) begin
            r_mtime <= r_mtime + MTIME_W'(1);
         end
      end
   end

   // Per-hart MSIP bits and MTIMECMP registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_msip <= '0;
         for (int h = 0; h < N_HARTS; h++) r_cmp[h] <= '1;
      end else if (w_wr) begin
         for (int h = 0; h < N_HARTS; h++) begin
            if (w_msip_hit && w_msip_idx == 12'(h) && bus.wstrb[0])
               r_msip[h] <= bus.wdata[0];
            if (w_cmp_hit && w_cmp_idx == 11'(h))
               r_cmp[h] <= w_cmp_new64[MTIME_W-1:0];
         end
      end
   end

   // Bus response: one-cycle ready, registered read data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ready <= bus.valid;
         if (bus.valid) r_rdata <= w_rval;
      end
   end

   // Registered interrupt outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mtip_o <= '0;
         r_msip_o <= '0;
      end else begin
         for (int h = 0; h < N_HARTS; h++) r_mtip_o[h] <= (r_mtime >= r_cmp[h]);
         r_msip_o <= r_msip;
      end
   end

   assign bus.ready = r_ready;
   assign bus.rdata = r_rdata;
   assign mtip      = r_mtip_o;
   assign msip      = r_msip_o;

endmodule

// File: tb/tb_clint_multi_hart.sv
// Directed bench for clint_multi_hart (2 harts, 64-bit MTIME).
// Expected values are hand-computed constants.
module tb_clint_multi_hart;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rtc = 1'b0;
   logic [1:0] mtip;
   logic [1:0] msip;
   logic [31:0] rd;
   int n_checks = 0;
   int n_fail = 0;

   clint_multi_hart_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   clint_multi_hart #(
      .N_HARTS(2), .ADDR_W(16), .DATA_W(32), .MTIME_W(64)
   ) dut (
      .clk(clk), .reset(rst_n), .rtc_in(rtc),
      .bus(bus), .mtip(mtip), .msip(msip)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic acc(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.address = a; bus.wdata = d; bus.wstrb = s;
      @(posedge clk); #1;
      bus.valid = 1'b0; bus.wstrb = 4'h0;
      chk("ready_hi", 64'(bus.ready), 64'd1);
      r = bus.rdata;
      @(posedge clk); #1;
      chk("ready_lo", 64'(bus.ready), 64'd0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      acc(a, d, 4'hF, dummy);
   endtask

   task automatic tick();
      @(posedge clk); #1 rtc = 1'b1;
      repeat (3) @(posedge clk);
      #1 rtc = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_mtip", 64'(mtip), 64'd0);
      chk("rst_msip", 64'(msip), 64'd0);
      chk("rst_ready", 64'(bus.ready), 64'd0);
      chk("rst_rdata", 64'(bus.rdata), 64'd0);

      acc(16'hBFF8, 0, 0, rd); chk("rst_mt_lo", 64'(rd), 64'd0);
      acc(16'hBFFC, 0, 0, rd); chk("rst_mt_hi", 64'(rd), 64'd0);
      acc(16'h4000, 0, 0, rd); chk("rst_c0_lo", 64'(rd), 64'hFFFFFFFF);
      acc(16'h4004, 0, 0, rd); chk("rst_c0_hi", 64'(rd), 64'hFFFFFFFF);
      acc(16'h4008, 0, 0, rd); chk("rst_c1_lo", 64'(rd), 64'hFFFFFFFF);
      acc(16'h400C, 0, 0, rd); chk("rst_c1_hi", 64'(rd), 64'hFFFFFFFF);
      acc(16'h0000, 0, 0, rd); chk("rst_msip0", 64'(rd), 64'd0);
      acc(16'h0004, 0, 0, rd); chk("rst_msip1", 64'(rd), 64'd0);

      // software interrupts
      wr(16'h0004, 32'h1);
      chk("msip_h1", 64'(msip), 64'h2);
      acc(16'h0004, 0, 0, rd); chk("msip1_rd", 64'(rd), 64'd1);
      wr(16'h0004, 32'h0);
      chk("msip_clr", 64'(msip), 64'h0);
      wr(16'h0000, 32'h1);
      chk("msip_h0", 64'(msip), 64'h1);
      acc(16'h0000, 32'h0, 4'h2, rd);
      chk("msip_strb", 64'(msip), 64'h1);
      wr(16'h0000, 32'hFFFFFFFE);
      acc(16'h0000, 0, 0, rd); chk("msip0_even", 64'(rd), 64'd0);
      chk("msip_even", 64'(msip), 64'h0);
      wr(16'h0008, 32'h1);
      acc(16'h0008, 0, 0, rd); chk("msip_h2", 64'(rd), 64'd0);
      chk("msip_h2_out", 64'(msip), 64'h0);

      // timer interrupt
      wr(16'h4004, 32'h0);
      wr(16'h4000, 32'd100);
      chk("mtip_pre", 64'(mtip), 64'h0);
      repeat (99) tick();
      acc(16'hBFF8, 0, 0, rd); chk("mt_99", 64'(rd), 64'd99);
      chk("mtip_99", 64'(mtip), 64'h0);
      @(posedge clk); #1 rtc = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("mtip_edge3", 64'(mtip), 64'h0);
      @(posedge clk); #1 chk("mtip_edge4", 64'(mtip), 64'h1);
      rtc = 1'b0;
      repeat (3) @(posedge clk);
      acc(16'hBFF8, 0, 0, rd); chk("mt_100", 64'(rd), 64'd100);
      wr(16'h4000, 32'd200);
      chk("mtip_clr", 64'(mtip), 64'h0);

      // write/tick collision
      @(posedge clk); #1 rtc = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.address = 16'hBFF8;
      bus.wdata = 32'h10; bus.wstrb = 4'hF;
      @(posedge clk); #1;
      bus.valid = 1'b0; bus.wstrb = 4'h0;
      chk("coll_ready", 64'(bus.ready), 64'd1);
      rtc = 1'b0;
      repeat (3) @(posedge clk);
      acc(16'hBFF8, 0, 0, rd); chk("coll_lo", 64'(rd), 64'h10);
      acc(16'hBFFC, 0, 0, rd); chk("coll_hi", 64'(rd), 64'h0);

      // wrap
      wr(16'h400C, 32'h0);
      wr(16'h4008, 32'd5);
      wr(16'hBFFC, 32'hFFFFFFFF);
      wr(16'hBFF8, 32'hFFFFFFFF);
      chk("wrap_mtip_pre", 64'(mtip), 64'h3);
      tick();
      @(posedge clk); #1;
      chk("wrap_mtip", 64'(mtip), 64'h0);
      acc(16'hBFF8, 0, 0, rd); chk("wrap_lo", 64'(rd), 64'd0);
      acc(16'hBFFC, 0, 0, rd); chk("wrap_hi", 64'(rd), 64'd0);

      // snapshot across carry
      wr(16'hBFFC, 32'h0);
      wr(16'hBFF8, 32'hFFFFFFFF);
      acc(16'hBFF8, 0, 0, rd); chk("snap_lo", 64'(rd), 64'hFFFFFFFF);
      tick();
      acc(16'hBFFC, 0, 0, rd);
`ifdef CLINT_MTIME_SNAPSHOT_EN
      chk("snap_hi", 64'(rd), 64'd0);
`else
      chk("snap_hi", 64'(rd), 64'd1);
`endif
      acc(16'h2000, 0, 0, rd); chk("unmapped", 64'(rd), 64'd0);
      acc(16'h4010, 0, 0, rd); chk("cmp_h2", 64'(rd), 64'd0);

      // reset during an access
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.address = 16'hBFFC; bus.wstrb = 4'h0;
      #3 rst_n = 1'b0;
      @(posedge clk); #1;
      bus.valid = 1'b0;
      chk("rst_mid_rdy", 64'(bus.ready), 64'd0);
      @(posedge clk); #1;
      chk("rst_mid_rdy2", 64'(bus.ready), 64'd0);
      rst_n = 1'b1;
      acc(16'hBFFC, 0, 0, rd); chk("rst_mid_hi", 64'(rd), 64'd0);
      acc(16'h4008, 0, 0, rd); chk("rst_mid_c1", 64'(rd), 64'hFFFFFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clint_multi_hart.md
Name: clint_multi_hart

Overview:
- Parametrised core-local interruptor for up to N_HARTS harts.
- Holds per-hart MSIP bits, per-hart MTIMECMP registers and one shared MTIME counter.
- MTIME is advanced by an asynchronous real-time tick that is synchronised into the single clk domain.
- Sits on the native valid/ready CPU peripheral bus and drives the mtip/msip vectors of the interrupt controller.

Parameters:
- N_HARTS, 2: number of harts; 1..16.
- ADDR_W, 16: bus address width.
- DATA_W, 32: bus data width; fixed at 32.
- MTIME_W, 64: counter and compare width; 33..64. Bits above MTIME_W read as 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rtc_in  in  1  real-time tick, asynchronous to clk; each rising edge = one MTIME increment.
- valid  in  1  bus request, one-cycle pulse per access.
- address  in  ADDR_W  byte address, word aligned.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes; all zero = read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  access done, one-cycle pulse.
- mtip  out  N_HARTS  machine timer interrupt pending, one bit per hart.
- msip  out  N_HARTS  machine software interrupt pending, one bit per hart.

Behaviour:
- Register map (byte offsets):
  - MSIP[h] = 0x0000+4h. Only bit 0 is stored; other bits read 0.
  - MTIMECMP[h] low word = 0x4000+8h; high word = +4.
  - MTIME low word = 0xBFF8; high word = 0xBFFC.
- Reset (reset=0, asynchronous):
  - MTIME=0; every MTIMECMP=all ones (MTIME_W bits); MSIP=0.
  - mtip=0, msip=0, ready=0, rdata=0.
  - Synchroniser and edge-detect flops cleared.
  - If reset is asserted mid-access, that access is dropped and no ready is issued.
- Handshake:
  - valid sampled at a clk rising edge; ready=1 on the following cycle, for exactly one cycle.
  - rdata is registered and held until the next access completes.
  - Back-to-back valid on consecutive cycles is legal; each one gets its own ready.
  - Writes honour wstrb per byte.
  - Unmapped addresses and harts >= N_HARTS: reads return 0, writes are ignored, ready is still issued.
- Tick:
  - rtc_in passes through a 2-flop synchroniser, then a registered rising-edge detector.
  - MTIME increments on the 3rd clk edge after rtc_in rises.
  - MTIME wraps from 2^MTIME_W-1 to 0 with no flag.
- Simultaneous events: a bus write to either MTIME word in the same cycle as a tick wins; that tick is lost and the written value is loaded unincremented.
- Interrupt outputs (registered, one cycle after any MTIME/MTIMECMP/MSIP change):
  - mtip[h] = (MTIME >= MTIMECMP[h]), unsigned compare over MTIME_W bits.
  - msip[h] = MSIP[h].
- Partial updates: writing one word of MTIMECMP takes effect immediately. Software ordering (high word to all ones first) avoids spurious mtip; hardware does not guard it.

Optional Feature:
- Macro: CLINT_MTIME_SNAPSHOT_EN.
- Defined:
  - A read of the MTIME low word latches MTIME[MTIME_W-1:32] into a shadow register in the same cycle.
  - The next read of the MTIME high word returns the shadow, giving a coherent 64-bit value across a carry.
  - Shadow resets to 0 and is reloaded on every low-word read.
  - A write to MTIME also updates the shadow.
- Undefined: the high-word read returns the live upper bits; no shadow register is instantiated.

Test Plan:
- Reset check: release reset, read every register → MTIME=0; MTIMECMP[0..N-1]=0xFFFFFFFF_FFFFFFFF; MSIP=0; mtip=0, msip=0; each ready exactly 1 cycle after valid.
- Software interrupt: write 1 to 0x0004 (hart 1) → msip=2'b10 one cycle after ready. Write 0 → msip=0. Write 0xFFFFFFFE to 0x0000 → MSIP[0] reads 0.
- Timer interrupt: write MTIMECMP[0]=100 (high word 0 first, then low), apply 100 rtc_in rising edges → mtip[0] rises the cycle after MTIME reaches 100; mtip[1] stays 0. Rewrite MTIMECMP[0]=200 → mtip[0] clears.
- Write/tick collision: write MTIME low = 0x10 in the same cycle the edge detector fires → MTIME reads 0x10, not 0x11.
- Wrap: load MTIME=0xFFFFFFFF_FFFFFFFF, one tick → MTIME=0. mtip of any hart with MTIMECMP=5 goes 1→0.
- Snapshot: MTIME=0x0_FFFFFFFF; read low, tick, read high → high=0 with CLINT_MTIME_SNAPSHOT_EN defined, high=1 without. Unmapped 0x2000 read → rdata=0, ready issued.
